// File: rtl/apb4_master_engine.sv
// APB4 requester: queued valid/ready commands become APB4 transfers; each completion is reported on a response channel.
// Optional ACCESS-phase timeout is built when APB4_MASTER_TIMEOUT_EN is defined.
module apb4_master_engine #(
  parameter int APB_AW      = 32,
  parameter int APB_DW      = 32,
  parameter int CMD_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [APB_AW-1:0]     cmd_addr,
  input  logic [APB_DW-1:0]     cmd_wdata,
  input  logic [APB_DW/8-1:0]   cmd_strb,
  input  logic [2:0]            cmd_prot,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [APB_DW-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic [APB_AW-1:0]     PADDR,
  output logic [2:0]            PPROT,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [APB_DW-1:0]     PWDATA,
  output logic [APB_DW/8-1:0]   PSTRB,
  input  logic                  PREADY,
  input  logic [APB_DW-1:0]     PRDATA,
  input  logic                  PSLVERR
);
  localparam int SW = APB_DW / 8;
  localparam int PW = $clog2(CMD_DEPTH);
  localparam int CW = $clog2(CMD_DEPTH + 1);

  typedef struct packed {
    logic              write;
    logic [APB_AW-1:0] addr;
    logic [APB_DW-1:0] wdata;
    logic [SW-1:0]     strb;
    logic [2:0]        prot;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  if ((APB_DW % 8) != 0 || CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 || TIMEOUT_CYC < 1)
  begin : g_cfg_err
    $error("apb4_master_engine: illegal parameter combination");
  end

  cmd_t          mem [CMD_DEPTH];
  cmd_t          head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          push, pop, done, abort, tmo_hit;
  state_t        state, state_nxt;

  assign push      = cmd_valid & cmd_ready;
  assign head      = mem[rd_ptr];
  assign count_nxt = count + CW'(push) - CW'(pop);

  always_ff @(posedge PCLK) begin
    if (push) mem[wr_ptr] <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata,
                               strb: cmd_strb, prot: cmd_prot};
  end

  // Pointers are PW bits wide, so they wrap modulo CMD_DEPTH for free.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count     <= count_nxt;
      cmd_ready <= (count_nxt != CW'(CMD_DEPTH));
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      S_IDLE:   if (count != '0) state_nxt = S_SETUP;
      S_SETUP:  state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (PREADY) begin
          done      = 1'b1;
          pop       = 1'b1;
          state_nxt = S_RESP;
        end else if (tmo_hit) begin
          abort     = 1'b1;
          pop       = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP:   if (rsp_ready) state_nxt = (count != '0) ? S_SETUP : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Payload is loaded on the way into SETUP; reads keep the old PWDATA.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      PADDR  <= '0;
      PPROT  <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
      PSTRB  <= '0;
    end else if (state_nxt == S_SETUP) begin
      PADDR  <= head.addr;
      PPROT  <= head.prot;
      PWRITE <= head.write;
      PSTRB  <= head.write ? head.strb : '0;
      if (head.write) PWDATA <= head.wdata;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (done) begin
      rsp_rdata <= PWRITE ? '0 : PRDATA;
      rsp_err   <= PSLVERR;
    end else if (abort) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b1;
    end
  end

`ifdef APB4_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN)               tmo_cnt <= '0;
    else if (state != S_ACCESS) tmo_cnt <= '0;
    else if (!PREADY)           tmo_cnt <= tmo_cnt + TW'(1);
  end

  // Expires on the wait cycle that would bring the count to TIMEOUT_CYC; PREADY wins in ACCESS.
  assign tmo_hit = (state == S_ACCESS) && !PREADY && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN)   rsp_timeout <= 1'b0;
    else if (done)  rsp_timeout <= 1'b0;
    else if (abort) rsp_timeout <= 1'b1;
  end
`else
  assign tmo_hit     = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  assign PSEL      = (state == S_SETUP) || (state == S_ACCESS);
  assign PENABLE   = (state == S_ACCESS);
  assign rsp_valid = (state == S_RESP);
  assign busy      = (count != '0) || (state != S_IDLE);
endmodule

// File: tb/tb_apb4_master_engine.sv
// Self-checking bench for apb4_master_engine: directed scenarios plus randomized traffic against a queue model.
module tb_apb4_master_engine;
  localparam int AW = 32, DW = 32, SW = 4, DEPTH = 4, TCYC = 8;

  logic PCLK = 1'b0, PRESETN = 1'b0;
  logic cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_strb = '0;
  logic [2:0]    cmd_prot = '0;
  logic cmd_ready, rsp_valid, rsp_err, rsp_timeout, busy;
  logic rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata, PWDATA;
  logic [DW-1:0] PRDATA = '0;
  logic [AW-1:0] PADDR;
  logic [2:0] PPROT;
  logic [SW-1:0] PSTRB;
  logic PSEL, PENABLE, PWRITE;
  logic PREADY = 1'b0, PSLVERR = 1'b0;

  apb4_master_engine #(.APB_AW(AW), .APB_DW(DW), .CMD_DEPTH(DEPTH), .TIMEOUT_CYC(TCYC)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .PADDR(PADDR), .PPROT(PPROT), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR));

  always #5 PCLK = ~PCLK;

  typedef struct { logic w; logic [AW-1:0] a; logic [DW-1:0] d; logic [SW-1:0] s; logic [2:0] p; } cmd_t;
  typedef struct { logic w; logic [AW-1:0] a; logic [DW-1:0] d; logic [SW-1:0] s; logic [2:0] p;
                   logic [DW-1:0] rd; logic err; } obs_t;
  typedef struct { logic [DW-1:0] rd; logic err; logic to; } rsp_t;

  cmd_t expq[$];
  obs_t obsq[$];
  rsp_t rspq[$];
  logic [DW-1:0] model_pwdata = '0;

  int checks = 0, fails = 0, cyc = 0;
  int fixed_wait = 0, max_wait = 0, wcnt = 0, done_cyc = 0, stab_errs = 0;
  bit hold = 0, wait_err = 0, done_err = 0, err_rand = 0, rand_data = 0, rr_rand = 0, rr_level = 1;
  logic [DW-1:0] prdata_fix = '0;
  logic [AW-1:0] sn_a; logic sn_w; logic [DW-1:0] sn_d; logic [SW-1:0] sn_s; logic [2:0] sn_p;

  always @(posedge PCLK) cyc <= cyc + 1;

  // Completer: decides this cycle's PREADY at the negedge, logs each completed transfer.
  always @(negedge PCLK) begin
    if (!PRESETN) begin
      PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0; wcnt = 0;
    end else if (PSEL && !PENABLE) begin
      wcnt = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(max_wait, 0));
      PREADY = 1'b0; PSLVERR = 1'b0;
      sn_a = PADDR; sn_w = PWRITE; sn_d = PWDATA; sn_s = PSTRB; sn_p = PPROT;
    end else if (PSEL && PENABLE) begin
      if ({PADDR, PWRITE, PWDATA, PSTRB, PPROT} !== {sn_a, sn_w, sn_d, sn_s, sn_p}) stab_errs++;
      if (!hold && wcnt == 0) begin
        PREADY  = 1'b1;
        PRDATA  = rand_data ? $urandom : prdata_fix;
        PSLVERR = err_rand ? ($urandom_range(1, 0) != 0) : done_err;
        obsq.push_back('{w: PWRITE, a: PADDR, d: PWDATA, s: PSTRB, p: PPROT, rd: PRDATA, err: PSLVERR});
        done_cyc = cyc;
      end else begin
        PREADY = 1'b0; PSLVERR = wait_err;
        if (!hold && wcnt > 0) wcnt--;
      end
    end else begin
      PREADY = 1'b0; PSLVERR = 1'b0;
    end
  end

  always @(negedge PCLK) begin
    rsp_ready = rr_rand ? ($urandom_range(3, 0) != 0) : rr_level;
    if (PRESETN && rsp_valid && rsp_ready) rspq.push_back('{rd: rsp_rdata, err: rsp_err, to: rsp_timeout});
  end

  // acc = number of the clock edge on which the command was accepted
  task automatic push(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [SW-1:0] s, input logic [2:0] p, output int acc);
    int n = 0;
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_prot = p;
    while (!cmd_ready && n < 200) begin @(negedge PCLK); n++; end
    checks++;
    if (!cmd_ready) begin
      fails++; acc = -1; cmd_valid = 1'b0;
      $display("FAIL push_accept: addr %h not accepted within 200 cycles", a);
      return;
    end
    acc = cyc + 1;
    expq.push_back('{w: w, a: a, d: d, s: s, p: p});
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int n, input string tag);
    int t = 0;
    cmd_t c; obs_t o; rsp_t r;
    logic [DW-1:0] exp_d;
    while (rspq.size() < n && t < 2000) begin @(posedge PCLK); t++; end
    checks++;
    if (rspq.size() < n) begin
      fails++; $display("FAIL %s rsp_count: got %0d want %0d", tag, rspq.size(), n);
    end
    while (rspq.size() > 0 && obsq.size() > 0 && expq.size() > 0) begin
      c = expq.pop_front(); o = obsq.pop_front(); r = rspq.pop_front();
      exp_d = c.w ? c.d : model_pwdata;
      if (c.w) model_pwdata = c.d;
      checks++;
      if ({o.w, o.a, o.d, o.s, o.p} !== {c.w, c.a, exp_d, (c.w ? c.s : 4'h0), c.p}) begin
        fails++;
        $display("FAIL %s apb_payload: got w=%b a=%h d=%h s=%h p=%h want w=%b a=%h d=%h s=%h p=%h",
                 tag, o.w, o.a, o.d, o.s, o.p, c.w, c.a, exp_d, (c.w ? c.s : 4'h0), c.p);
      end
      checks++;
      if (r.rd !== (c.w ? 32'h0 : o.rd) || r.err !== o.err || r.to !== 1'b0) begin
        fails++;
        $display("FAIL %s response: got rd=%h err=%b to=%b want rd=%h err=%b to=0",
                 tag, r.rd, r.err, r.to, (c.w ? 32'h0 : o.rd), o.err);
      end
    end
    checks++;
    if (stab_errs != 0) begin
      fails++; $display("FAIL %s payload_stable: got %0d changes want 0", tag, stab_errs);
      stab_errs = 0;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge PCLK);
    #1;
    checks++;
    if ({cmd_ready, PSEL, PENABLE, rsp_valid, busy, PWRITE, rsp_err, rsp_timeout} !== 8'b1000_0000 ||
        PADDR !== '0 || PWDATA !== '0 || PSTRB !== '0 || PPROT !== '0 || rsp_rdata !== '0) begin
      fails++;
      $display("FAIL reset_state: got rdy=%b sel=%b en=%b rv=%b busy=%b addr=%h wd=%h want rdy=1, rest 0",
               cmd_ready, PSEL, PENABLE, rsp_valid, busy, PADDR, PWDATA);
    end
    @(negedge PCLK); PRESETN = 1'b1;
  endtask

  task automatic test_write_basic;
    int acc;
    fixed_wait = 0; done_err = 0; rr_level = 1;
    push(1'b1, 32'h10, 32'hA5A55A5A, 4'hF, 3'b010, acc);
    @(posedge PCLK); #1;
    checks++;
    if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PADDR !== 32'h10) begin
      fails++; $display("FAIL wr_setup: got sel=%b en=%b addr=%h want 1 0 00000010", PSEL, PENABLE, PADDR);
    end
    @(posedge PCLK); #1;
    checks++;
    if (PSEL !== 1'b1 || PENABLE !== 1'b1 || PSTRB !== 4'hF || PPROT !== 3'd2 || PWRITE !== 1'b1) begin
      fails++; $display("FAIL wr_access: got sel=%b en=%b strb=%h prot=%0d want 1 1 f 2", PSEL, PENABLE, PSTRB, PPROT);
    end
    @(posedge PCLK); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 || PSEL !== 1'b0) begin
      fails++; $display("FAIL wr_resp: got rv=%b err=%b rd=%h sel=%b want 1 0 0 0", rsp_valid, rsp_err, rsp_rdata, PSEL);
    end
    drain(1, "write_basic");
  endtask

  task automatic test_read_wait;
    int acc, en_cnt = 0, t = 0;
    fixed_wait = 3; rand_data = 0; prdata_fix = 32'h12345678;
    push(1'b0, 32'h24, 32'hDEADBEEF, 4'hF, 3'b001, acc);
    while (t < 50) begin
      @(posedge PCLK); #1; t++;
      if (PENABLE) en_cnt++;
      if (rsp_valid) break;
    end
    checks++;
    if (en_cnt != 4 || rsp_rdata !== 32'h12345678 || PSTRB !== 4'h0) begin
      fails++; $display("FAIL rd_wait: got en_cycles=%0d rd=%h strb=%h want 4 12345678 0", en_cnt, rsp_rdata, PSTRB);
    end
    drain(1, "read_wait");
  endtask

  task automatic test_slverr;
    int acc;
    fixed_wait = 2; wait_err = 1; done_err = 0;
    push(1'b1, 32'h30, 32'h0000_1111, 4'h3, 3'b000, acc);
    drain(1, "slverr_wait_pulse");
    wait_err = 0; done_err = 1;
    push(1'b1, 32'h34, 32'h0000_2222, 4'hC, 3'b100, acc);
    drain(1, "slverr_done");
    done_err = 0; fixed_wait = 0;
  endtask

  task automatic test_fifo_full;
    int acc, a5;
    hold = 1; fixed_wait = 0;
    for (int i = 0; i < 4; i++) push(1'b1, 32'h100 + 32'(i * 4), $urandom, 4'hF, 3'($urandom), acc);
    checks++;
    if (cmd_ready !== 1'b0) begin
      fails++; $display("FAIL fifo_full_ready: got %b want 0", cmd_ready);
    end
    hold = 0;
    push(1'b0, 32'h110, 32'h0, 4'h0, 3'b000, a5);
    checks++;
    if (a5 != done_cyc + 2) begin
      fails++; $display("FAIL fifo_5th_accept: got edge %0d want %0d", a5, done_cyc + 2);
    end
    drain(5, "fifo_full");
  endtask

`ifdef APB4_MASTER_TIMEOUT_EN
  task automatic test_timeout;
    int acc, en_cnt = 0, t = 0;
    cmd_t c; rsp_t r;
    hold = 1;
    push(1'b0, 32'h200, 32'h0, 4'h0, 3'b011, acc);
    push(1'b1, 32'h204, 32'h5555_AAAA, 4'h5, 3'b001, acc);
    while (t < 50) begin
      @(posedge PCLK); #1; t++;
      if (PENABLE) en_cnt++;
      if (rsp_valid) break;
    end
    hold = 0;
    checks++;
    if (en_cnt != TCYC || rsp_err !== 1'b1 || rsp_timeout !== 1'b1 || rsp_rdata !== '0) begin
      fails++; $display("FAIL timeout_abort: got en_cycles=%0d err=%b to=%b rd=%h want %0d 1 1 0",
                        en_cnt, rsp_err, rsp_timeout, rsp_rdata, TCYC);
    end
    t = 0;
    while (rspq.size() < 1 && t < 100) begin @(posedge PCLK); t++; end
    checks++;
    if (rspq.size() < 1) begin
      fails++; $display("FAIL timeout_rsp_count: got 0 want 1");
    end else begin
      r = rspq.pop_front(); c = expq.pop_front();
      if (r.to !== 1'b1 || r.err !== 1'b1) begin
        fails++; $display("FAIL timeout_rsp: got err=%b to=%b want 1 1", r.err, r.to);
      end
    end
    drain(1, "after_timeout");
  endtask
`endif

  task automatic test_rsp_hold_reset;
    int acc, t = 0;
    logic [DW-1:0] s_rd; logic s_err, s_to;
    bit bad = 0;
    fixed_wait = 0; hold = 0; rr_level = 0;
    push(1'b0, 32'h300, 32'h0, 4'h0, 3'b000, acc);
    push(1'b1, 32'h304, 32'h7777_0000, 4'hF, 3'b000, acc);
    push(1'b1, 32'h308, 32'h8888_0000, 4'hF, 3'b000, acc);
    while (!rsp_valid && t < 50) begin @(posedge PCLK); #1; t++; end
    s_rd = rsp_rdata; s_err = rsp_err; s_to = rsp_timeout;
    for (int i = 0; i < 10; i++) begin
      @(posedge PCLK); #1;
      if (rsp_valid !== 1'b1 || rsp_rdata !== s_rd || rsp_err !== s_err || rsp_to_chk(s_to) || PSEL !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      fails++; $display("FAIL rsp_hold: got rv=%b sel=%b rd=%h want stable response, no SETUP", rsp_valid, PSEL, rsp_rdata);
    end
    hold = 1; rr_level = 1;
    t = 0;
    while (!PENABLE && t < 50) begin @(posedge PCLK); #1; t++; end
    drain(1, "rsp_hold");
    @(negedge PCLK); PRESETN = 1'b0; #1;
    checks++;
    if ({PSEL, PENABLE, rsp_valid, busy, cmd_ready} !== 5'b00001) begin
      fails++; $display("FAIL reset_mid_access: got sel=%b en=%b rv=%b busy=%b rdy=%b want 0 0 0 0 1",
                        PSEL, PENABLE, rsp_valid, busy, cmd_ready);
    end
    expq.delete(); obsq.delete(); rspq.delete(); model_pwdata = '0; hold = 0;
    repeat (2) @(negedge PCLK);
    PRESETN = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge PCLK); #1;
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || PSEL !== 1'b0) bad = 1;
    end
    checks++;
    if (bad || rspq.size() != 0) begin
      fails++; $display("FAIL reset_discard: got busy=%b rv=%b rsps=%0d want 0 0 0", busy, rsp_valid, rspq.size());
    end
  endtask

  function automatic bit rsp_to_chk(input logic s_to);
    return rsp_timeout !== s_to;
  endfunction

  task automatic test_random;
    int acc;
    fixed_wait = -1; max_wait = 3; rand_data = 1; err_rand = 1; rr_rand = 1;
    for (int i = 0; i < 40; i++) begin
      push(1'($urandom), $urandom & 32'h0000_FFFC, $urandom, 4'($urandom), 3'($urandom), acc);
      repeat ($urandom_range(2, 0)) @(posedge PCLK);
    end
    drain(40, "random");
    rr_rand = 0; err_rand = 0; rand_data = 0; fixed_wait = 0;
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_wait();
    test_slverr();
    test_fifo_full();
`ifdef APB4_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    test_rsp_hold_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/apb4_master_engine.md
Name: apb4_master_engine

Overview:
Parametrised APB4 requester that turns a queued valid/ready command stream into APB4 transfers. It adds PSTRB and PPROT support and configurable address and data widths, and reports each completed transfer on a valid/ready response channel. It sits between the team's internal bus fabric or testbench sequencers and APB-attached peripherals such as the UART register block.

Parameters:
APB_AW, 32, address width in bits.
APB_DW, 32, data width in bits; must be a multiple of 8; strobe width is APB_DW/8.
CMD_DEPTH, 4, command FIFO depth; power of 2, minimum 2.
TIMEOUT_CYC, 256, ACCESS-phase cycle limit; used only when APB4_MASTER_TIMEOUT_EN is defined; minimum 1.

Ports:
PCLK  in  1  clock; all logic on rising edge.
PRESETN  in  1  asynchronous active-low reset.
cmd_valid  in  1  command offered.
cmd_ready  out  1  high when the FIFO is not full.
cmd_write  in  1  1 = write, 0 = read.
cmd_addr  in  APB_AW  transfer address.
cmd_wdata  in  APB_DW  write data.
cmd_strb  in  APB_DW/8  write byte strobes.
cmd_prot  in  3  PPROT value for the transfer.
rsp_valid  out  1  response available.
rsp_ready  in  1  response consumed.
rsp_rdata  out  APB_DW  read data; 0 for writes.
rsp_err  out  1  PSLVERR or timeout.
rsp_timeout  out  1  transfer aborted by timeout.
busy  out  1  high when the FIFO is not empty or state is not IDLE.
PADDR  out  APB_AW  APB address.
PPROT  out  3  APB protection.
PSEL  out  1  APB select.
PENABLE  out  1  APB enable.
PWRITE  out  1  APB direction.
PWDATA  out  APB_DW  APB write data.
PSTRB  out  APB_DW/8  APB write strobes.
PREADY  in  1  completer ready.
PRDATA  in  APB_DW  completer read data.
PSLVERR  in  1  completer error.

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0, except cmd_ready = 1.
  - FIFO is emptied; FSM goes to IDLE.
  - Reset asserted mid-transfer drops PSEL and PENABLE immediately, discards queued commands, and produces no response.
- Command FIFO:
  - Push on cmd_valid & cmd_ready.
  - Pop only when a transfer completes or times out.
  - cmd_ready is registered as !full.
  - Push and pop in the same cycle leave the count unchanged.
  - Read and write pointers wrap modulo CMD_DEPTH.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - PSEL = 0, PENABLE = 0.
  - If the FIFO is not empty, go to SETUP next cycle.
  - A command accepted at edge k gives PSEL = 1 from edge k+1 (the IDLE decision is combinational on the registered FIFO count).
- SETUP (exactly 1 cycle):
  - PSEL = 1, PENABLE = 0.
  - PADDR, PPROT, PWRITE, PWDATA, PSTRB are loaded from the FIFO head.
  - For reads, PSTRB = 0 and PWDATA holds its previous value.
  - Go to ACCESS.
- ACCESS:
  - PSEL = 1, PENABLE = 1; all payload signals held stable.
  - On PREADY = 1:
    - capture PRDATA (reads only) and PSLVERR; rsp_timeout = 0;
    - pop the FIFO; go to RESP.
  - PSLVERR is ignored while PREADY = 0.
- RESP:
  - PSEL = 0, PENABLE = 0, rsp_valid = 1.
  - Response fields are stable until rsp_ready.
  - On rsp_ready: go to SETUP if the FIFO is not empty (back-to-back), else IDLE.
  - No new transfer starts while a response is pending.
- Throughput: zero-wait-state transfers with rsp_ready tied high complete in 3 cycles each.
- Outside SETUP/ACCESS: PADDR, PPROT, PWRITE, PWDATA and PSTRB hold their last values.

Optional Feature:
APB4_MASTER_TIMEOUT_EN:
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY = 0.
  - When the count reaches TIMEOUT_CYC, the transfer is aborted: PSEL and PENABLE drop, the FIFO pops, and the FSM goes to RESP with rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
  - PREADY arriving in the same cycle as expiry wins: normal completion.
- Undefined:
  - No counter is built; ACCESS waits indefinitely.
  - rsp_timeout is tied to 0.

Test Plan:
1. Push write addr 0x10, wdata 0xA5A55A5A, strb 0xF, prot 3'b010 at edge k; PREADY = 1 -> PSEL rises at k+1, PENABLE at k+2 with PSTRB = 0xF and PPROT = 2; rsp_valid at k+3 with rsp_err = 0, rsp_rdata = 0.
2. Read addr 0x24; PREADY low 3 cycles, then high with PRDATA = 0x12345678 -> PENABLE high 4 cycles, PSTRB = 0, payload stable throughout; rsp_rdata = 0x12345678.
3. Write completes with PREADY = 1, PSLVERR = 1 -> rsp_err = 1, rsp_timeout = 0. A PSLVERR = 1 pulse during a wait state is ignored.
4. CMD_DEPTH = 4, PREADY held low, 5 commands offered -> 4 accepted and cmd_ready = 0; the 5th is accepted the cycle after the first completes. All 5 are issued in order with correct addresses.
5. TIMEOUT_EN defined, TIMEOUT_CYC = 8, PREADY stuck low -> PSEL drops after 8 ACCESS cycles; rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0; the next queued command then issues normally.
6. rsp_ready held low 10 cycles with 2 commands queued -> rsp fields are stable and no second SETUP occurs. Then assert PRESETN = 0 mid-ACCESS of the next transfer -> PSEL = 0 immediately, rsp_valid = 0, busy = 0, cmd_ready = 1.
